// File: rtl/unit_clause_scan_pkg.sv
// Shared formula types and scan FSM encoding for the unit clause scanner.
// Optional feature macro: UNIT_COUNT_EN (see unit_clause_scan.sv).
package unit_clause_scan_pkg;

    localparam int number_clauses = 16;
    localparam int max_lits       = 3;
    localparam int lit_w          = 8;

    // Wide enough to hold any clause index plus the one-past-the-end value.
    localparam int clause_idx_w   = $clog2(number_clauses) + 1;

    typedef logic [lit_w-1:0] lit;

    typedef struct packed {
        logic [1:0]             len;
        lit [max_lits-1:0]      lits;
    } clause;

    typedef struct packed {
        logic [clause_idx_w-1:0]    len;
        clause [number_clauses-1:0] clauses;
    } formula;

    localparam lit     zero_lit     = '0;
    localparam formula zero_formula = '0;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_t;

endpackage

// File: rtl/unit_clause_scan_window.sv
// Combinational evaluation of one scan window of LANES clauses.
// Reports the lowest empty clause (conflict) with priority over the lowest
// unit clause. With UNIT_COUNT_EN it also counts unit clauses in the window.
module unit_clause_scan_window
    import unit_clause_scan_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IDX_W = clause_idx_w
) (
    input  clause            lanes [LANES],
    input  logic [LANES-1:0] valid,
    input  logic [IDX_W-1:0] base,
    output logic             has_empty,
    output logic             has_unit,
    output logic [IDX_W-1:0] first_idx,
    output lit               first_lit
`ifdef UNIT_COUNT_EN
    ,
    output logic [IDX_W-1:0] unit_cnt
`endif
);

    logic [IDX_W-1:0] empty_idx;
    logic [IDX_W-1:0] unit_idx;
    lit               unit_lit;
    logic [LANES-1:0] unused_lits;

    // Priority scan from lane 0 upward: first match in each category wins.
    always_comb begin
        has_empty = 1'b0;
        has_unit  = 1'b0;
        empty_idx = '0;
        unit_idx  = '0;
        unit_lit  = zero_lit;
`ifdef UNIT_COUNT_EN
        unit_cnt  = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            unused_lits[i] = ^lanes[i].lits[max_lits-1:1];
            if (valid[i] && lanes[i].len == 2'd0 && !has_empty) begin
                has_empty = 1'b1;
                empty_idx = base + IDX_W'(i);
            end
            if (valid[i] && lanes[i].len == 2'd1) begin
`ifdef UNIT_COUNT_EN
                unit_cnt = unit_cnt + IDX_W'(1);
`endif
                if (!has_unit) begin
                    has_unit = 1'b1;
                    unit_idx = base + IDX_W'(i);
                    unit_lit = lanes[i].lits[0];
                end
            end
        end
        first_idx = has_empty ? empty_idx : unit_idx;
        first_lit = has_empty ? zero_lit : unit_lit;
    end

endmodule

// File: rtl/unit_clause_scan.sv
// Scans a latched formula LANES clauses per cycle for the lowest-index unit
// clause, detecting empty clauses (conflicts) with priority over units.
// Optional feature macro: UNIT_COUNT_EN adds a unit_count output and makes the
// scan run over the whole formula (stopping early only on a conflict).
//
// Handshake: start is sampled only while idle (busy=0); a scan in progress
// ignores start and in_formula. busy is high for every cycle spent scanning.
// done pulses for exactly one cycle when found/conflict/lit_found/clause_idx
// become valid; those results are then held until the next accepted start.
module unit_clause_scan
    import unit_clause_scan_pkg::*;
#(
    parameter int NUM_CLAUSES = number_clauses,
    parameter int LANES       = 4,
    parameter int IDX_W       = $clog2(NUM_CLAUSES) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  formula           in_formula,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             conflict,
    output lit               lit_found,
    output logic [IDX_W-1:0] clause_idx
`ifdef UNIT_COUNT_EN
    ,
    output logic [IDX_W-1:0] unit_count
`endif
);

    localparam int CW = (number_clauses > 1) ? $clog2(number_clauses) : 1;

    scan_state_t      state;
    formula           form_q;
    logic [IDX_W-1:0] base_q;
    logic [IDX_W-1:0] limit_q;

    logic [IDX_W-1:0] req_len;
    logic [IDX_W-1:0] req_limit;
    logic [IDX_W:0]   next_base;
    logic             last_window;

    clause            lane_clause [LANES];
    logic [LANES-1:0] lane_valid;
    logic [IDX_W-1:0] lane_idx    [LANES];

    logic             win_empty;
    logic             win_unit;
    logic [IDX_W-1:0] win_idx;
    lit               win_lit;
`ifdef UNIT_COUNT_EN
    logic [IDX_W-1:0] win_units;
`endif

    logic             unused_bits;

    // Clamp the requested formula length to the clause capacity.
    always_comb begin
        req_len   = IDX_W'(in_formula.len);
        req_limit = (req_len > IDX_W'(NUM_CLAUSES)) ? IDX_W'(NUM_CLAUSES) : req_len;
    end

    // Window bookkeeping: the scan ends once the window reaches the limit.
    always_comb begin
        next_base   = {1'b0, base_q} + (IDX_W+1)'(LANES);
        last_window = (next_base >= {1'b0, limit_q});
        unused_bits = ^form_q.len;
    end

    // Gather the current window's clauses; lanes at or past the limit are masked.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_idx[i]   = base_q + IDX_W'(i);
            lane_valid[i] = (lane_idx[i] < limit_q);
            if (lane_idx[i] < IDX_W'(number_clauses)) begin
                lane_clause[i] = form_q.clauses[lane_idx[i][CW-1:0]];
            end else begin
                lane_clause[i] = '0;
            end
        end
    end

    unit_clause_scan_window #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_window (
        .lanes     (lane_clause),
        .valid     (lane_valid),
        .base      (base_q),
        .has_empty (win_empty),
        .has_unit  (win_unit),
        .first_idx (win_idx),
        .first_lit (win_lit)
`ifdef UNIT_COUNT_EN
        ,
        .unit_cnt  (win_units)
`endif
    );

    // Scan FSM with registered handshake and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            conflict   <= 1'b0;
            lit_found  <= zero_lit;
            clause_idx <= '0;
            form_q     <= zero_formula;
            base_q     <= '0;
            limit_q    <= '0;
`ifdef UNIT_COUNT_EN
            unit_count <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        form_q     <= in_formula;
                        limit_q    <= req_limit;
                        base_q     <= '0;
                        found      <= 1'b0;
                        conflict   <= 1'b0;
                        lit_found  <= zero_lit;
                        clause_idx <= '0;
`ifdef UNIT_COUNT_EN
                        unit_count <= '0;
`endif
                        busy       <= 1'b1;
                        state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
`ifdef UNIT_COUNT_EN
                    unit_count <= unit_count + win_units;
                    if (win_empty) begin
                        conflict   <= 1'b1;
                        found      <= 1'b0;
                        clause_idx <= win_idx;
                        lit_found  <= zero_lit;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        if (win_unit && !found) begin
                            found      <= 1'b1;
                            clause_idx <= win_idx;
                            lit_found  <= win_lit;
                        end
                        if (last_window) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            base_q <= next_base[IDX_W-1:0];
                        end
                    end
`else
                    if (win_empty) begin
                        conflict   <= 1'b1;
                        found      <= 1'b0;
                        clause_idx <= win_idx;
                        lit_found  <= zero_lit;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (win_unit) begin
                        found      <= 1'b1;
                        clause_idx <= win_idx;
                        lit_found  <= win_lit;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (last_window) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        base_q <= next_base[IDX_W-1:0];
                    end
`endif
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
